// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, with a
// registered carry between chunks. Valid/ready on both sides.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MSB = WIDTH - 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] areg, breg, wreg, res_n;
    logic             creg;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   part;
    logic             last, accept;

    assign last   = (cnt == CW'(NCH - 1));
    assign accept = in_valid && in_ready;
    assign part   = {1'b0, areg[cnt*CHUNK +: CHUNK]}
                  + {1'b0, breg[cnt*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, creg};

    // Working result with the current chunk merged in; becomes sum on the last chunk.
    always_comb begin
        res_n = wreg;
        res_n[cnt*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_n = in_valid ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            wreg <= '0;
            creg <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (accept) begin
            // Subtraction folds into addition: a + ~b + !cin == a - b - cin.
            areg <= a;
            breg <= sub ? ~b : b;
            creg <= cin ^ sub;
            wreg <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            wreg <= res_n;
            creg <= part[CHUNK];
            cnt  <= last ? '0 : cnt + 1'b1;
            if (last) begin
                sum  <= res_n;
                cout <= part[CHUNK];
                ovf  <= (areg[MSB] == breg[MSB]) && (res_n[MSB] != areg[MSB]);
                zero <= (res_n == '0);
            end
        end
    end
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: CHUNK=4 and CHUNK=16 instances on shared stimulus,
// checked every cycle against a transaction-level arithmetic model.
module tb_chunked_addsub;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, cin, sub, out_ready;
    logic [W-1:0] a, b;
    logic [1:0]   ir, ov, co, of, zr;
    logic [W-1:0] sm [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm[0]), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sm[1]), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

    always #5 clk = ~clk;

    typedef struct packed {
        logic         cout;
        logic         ovf;
        logic [W-1:0] s;
    } res_t;

    // Plain integer arithmetic: unsigned for sum/carry, signed range test for overflow.
    function automatic res_t calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s);
        res_t   r;
        longint ux, uy, t, sx, sy, st;
        ux = longint'(x);
        uy = longint'(y);
        if (!s) begin
            t = ux + uy + longint'(c);
            r.cout = (t >= (longint'(1) << W));
        end else begin
            t = ux - uy - longint'(c);
            r.cout = (t >= 0);
        end
        r.s = t[W-1:0];
        sx = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy = y[W-1] ? uy - (longint'(1) << W) : uy;
        st = s ? sx - sy - longint'(c) : sx + sy + longint'(c);
        r.ovf = (st > (longint'(1) << (W-1)) - 1) || (st < -(longint'(1) << (W-1)));
        return r;
    endfunction

    // Transaction model per instance: pending result, cycles left, presenting flag.
    bit           busy [2];
    bit           pres [2];
    int           cnt  [2];
    res_t         pend [2];
    logic [W-1:0] esum [2];
    bit           ecout[2];
    bit           eovf [2];
    bit           ezero[2];

    function automatic bit mready(input int i);
        return !rst && !busy[i] && (!pres[i] || out_ready);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy[i] <= 0; pres[i] <= 0; cnt[i] <= 0;
                esum[i] <= '0; ecout[i] <= 0; eovf[i] <= 0; ezero[i] <= 0;
            end else begin
                if (busy[i]) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) begin
                        busy[i]  <= 0;
                        pres[i]  <= 1;
                        esum[i]  <= pend[i].s;
                        ecout[i] <= pend[i].cout;
                        eovf[i]  <= pend[i].ovf;
                        ezero[i] <= (pend[i].s == '0);
                    end
                end else if (pres[i] && out_ready) begin
                    pres[i] <= 0;
                end
                if (in_valid && mready(i)) begin
                    pend[i] <= calc(a, b, cin, sub);
                    busy[i] <= 1;
                    pres[i] <= 0;
                    cnt[i]  <= (i == 0) ? 4 : 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("out_valid", i, 32'(ov[i]), 32'(pres[i]));
                chk("in_ready",  i, 32'(ir[i]), 32'(mready(i)));
                chk("sum",       i, 32'(sm[i]), 32'(esum[i]));
                chk("cout",      i, 32'(co[i]), 32'(ecout[i]));
                chk("ovf",       i, 32'(of[i]), 32'(eovf[i]));
                chk("zero",      i, 32'(zr[i]), 32'(ezero[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called just after an acceptance edge; measures latency of both instances.
    task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec,
                               input logic eo, input logic ez, input int lat4);
        int l4 = -1;
        int l16 = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov[0] && l4 < 0) begin
                l4 = k;
                chk({nm, "_sum"},  0, 32'(sm[0]), 32'(es));
                chk({nm, "_cout"}, 0, 32'(co[0]), 32'(ec));
                chk({nm, "_ovf"},  0, 32'(of[0]), 32'(eo));
                chk({nm, "_zero"}, 0, 32'(zr[0]), 32'(ez));
            end
            if (ov[1] && l16 < 0) begin
                l16 = k;
                chk({nm, "_sum16"}, 1, 32'(sm[1]), 32'(es));
            end
        end
        chk({nm, "_latency"},   0, 32'(l4),  32'(lat4));
        chk({nm, "_latency16"}, 1, 32'(l16), 32'd1);
        tick();
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input logic [W-1:0] es,
                         input logic ec, input logic eo, input logic ez);
        a = x; b = y; cin = c; sub = s; in_valid = 1;
        tick();
        in_valid = 0;
        wait_result(nm, es, ec, eo, ez, 4);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        res_t r;
        int   hold;
        rst = 1; in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_in_ready",  0, 32'(ir[0]), 32'd0);
        tick();
        rst = 0;
        tick();

        r = calc(16'hABCD, 16'h1234, 1'b1, 1'b0);
        chk("model_add", 0, 32'(r), 32'({1'b0, 1'b0, 16'hBE02}));
        r = calc(16'h8000, 16'h0001, 1'b0, 1'b1);
        chk("model_sub_ovf", 0, 32'(r), 32'({1'b1, 1'b1, 16'h7FFF}));
        r = calc(16'h0000, 16'h0000, 1'b1, 1'b1);
        chk("model_borrow", 0, 32'(r), 32'({1'b0, 1'b0, 16'hFFFF}));

        do_op("basic", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 0);
        do_op("wrap",  16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
        do_op("sovf",  16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        do_op("sub1",  16'h1234, 16'h0234, 0, 1, 16'h1000, 1, 0, 0);
        do_op("sub2",  16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0, 0);

        // Back-pressure: hold result in DONE, then retire and accept on one edge.
        out_ready = 0;
        a = 16'h0100; b = 16'h0020; cin = 0; sub = 0; in_valid = 1;
        tick();
        in_valid = 0;
        hold = 0;
        while (!ov[0] && hold < 10) begin
            tick();
            hold++;
        end
        chk("bp_reached_done", 0, 32'(ov[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_sum",   0, 32'(sm[0]), 32'h0120);
            chk("bp_hold_ready", 0, 32'(ir[0]), 32'd0);
        end
        @(posedge clk);
        #2;
        out_ready = 1; in_valid = 1; a = 16'hABCD; b = 16'h1234; cin = 1;
        tick();
        in_valid = 0; cin = 0;
        wait_result("b2b", 16'hBE02, 0, 0, 0, 4);

        // Reset after two chunks of RUN aborts the operation.
        a = 16'h1111; b = 16'h2222; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        rst = 1;
        tick();
        @(negedge clk);
        chk("midrst_valid", 0, 32'(ov[0]), 32'd0);
        chk("midrst_sum",   0, 32'(sm[0]), 32'd0);
        rst = 0;
        tick();
        chk("midrst_ready", 0, 32'(ir[0]), 32'd1);
        do_op("post_rst", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 0);

        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 99) == 0);
            a   = pick();
            b   = pick();
            cin = 1'($urandom);
            sub = 1'($urandom);
            tick();
        end
        rst = 0; in_valid = 0; out_ready = 1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
